conv_stream_mc: RTL and testbench

Streaming 2-D convolution engine: the parametrised, multi-channel successor to `conv_final`. It accepts a raster-order pixel stream with a ready/valid handshake and buffers K-1 image rows. It applies C_OUT kernels in parallel to every KxK window at a configurable stride, then emits one C_OUT-wide output word per window with fixed-point rescale, saturation and optional ReLU. It sits between the input pixel source and `max_pooling`, or a following layer, and can stall under downstream backpressure.

---
 rtl/cnn_pkg.sv | 39 +++
 rtl/line_buffer.sv | 38 +++
 rtl/conv_stream_mc.sv | 179 +++++++++++++++++
 tb/tb_conv_stream_mc.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared helpers for the streaming CNN blocks (conv_stream_mc, max_pooling):
// width helpers and the rescale saturation/ReLU stage.
package cnn_pkg;

  localparam int unsigned SAT_W = 64;

  // Ceiling log2, floored at 1 so it can size a port directly
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = 1;
    while (x < v) begin
      x = x << 1;
      r++;
    end
    return (r == 0) ? 1 : r;
  endfunction

  function automatic int unsigned acc_w(input int unsigned dw, input int unsigned k);
    return 2 * dw + clog2(k * k);
  endfunction

  function automatic logic signed [SAT_W-1:0] sat_relu(input logic signed [SAT_W-1:0] v,
                                                       input int unsigned dw,
                                                       input bit relu);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    logic signed [SAT_W-1:0] r;
    hi = signed'((SAT_W'(1) << (dw - 1)) - SAT_W'(1));
    lo = ~hi;
    r  = v;
    if (v > hi) r = hi;
    else if (v < lo) r = lo;
    if (relu && (r < 0)) r = '0;
    return r;
  endfunction

endpackage

// File: rtl/line_buffer.sv
// ROWS x N pixel line store; a write at column col pushes the pixel into the
// bottom of that column and returns all stored rows of the column (row 0 oldest).
module line_buffer
  import cnn_pkg::*;
#(
  parameter int unsigned N    = 28,
  parameter int unsigned ROWS = 2,
  parameter int unsigned DW   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [clog2(N)-1:0]    col,
  input  logic [DW-1:0]          din,
  output logic [ROWS*DW-1:0]     col_data_c
);

  logic [DW-1:0] mem [ROWS][N];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned r = 0; r < ROWS; r++)
        for (int unsigned n = 0; n < N; n++)
          mem[r][n] <= '0;
    end else if (wr_en) begin
      for (int unsigned r = 0; r + 1 < ROWS; r++)
        mem[r][col] <= mem[r+1][col];
      mem[ROWS-1][col] <= din;
    end
  end

  always_comb begin
    col_data_c = '0;
    for (int unsigned r = 0; r < ROWS; r++)
      col_data_c[r*DW +: DW] = mem[r][col];
  end

endmodule

// File: rtl/conv_stream_mc.sv
// Streaming KxK multi-channel convolution with stride, rescale, saturation and
// optional ReLU; single-entry output register with ready/valid backpressure.
module conv_stream_mc
  import cnn_pkg::*;
#(
  parameter int unsigned N        = 28,
  parameter int unsigned M        = 28,
  parameter int unsigned K        = 3,
  parameter int unsigned K_stride = 1,
  parameter int unsigned DW       = 16,
  parameter int unsigned C_OUT    = 4,
  parameter int unsigned FRAC     = 0,
  parameter int unsigned RELU     = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [DW-1:0]               pxl_in,
  input  logic                        i_data_valid,
  output logic                        o_in_ready,
  input  logic [C_OUT*K*K*DW-1:0]     i_kernel_data,
  input  logic                        i_kernel_load,
  output logic [C_OUT*DW-1:0]         pxl_out,
  output logic                        o_data_valid,
  input  logic                        i_out_ready,
  output logic [clog2(M)-1:0]         o_row,
  output logic [clog2(N)-1:0]         o_col,
  output logic                        o_frame_done
);

  localparam int unsigned CW    = clog2(N);
  localparam int unsigned RW    = clog2(M);
  localparam int unsigned SW    = clog2(K_stride);
  localparam int unsigned ACC_W = acc_w(DW, K);
  localparam int unsigned OH    = (M - K) / K_stride + 1;
  localparam int unsigned OW    = (N - K) / K_stride + 1;

  logic [CW-1:0] col, ocol;
  logic [RW-1:0] row, orow;
  logic [SW-1:0] cph, rph;

  logic signed [DW-1:0] win  [K][K];
  logic signed [DW-1:0] nwin [K][K];
  logic signed [DW-1:0] wt   [C_OUT][K][K];

  logic [(K-1)*DW-1:0]  lb_col_c;
  logic [C_OUT*DW-1:0]  res_c;
  logic signed [ACC_W-1:0] acc;
  logic signed [SAT_W-1:0] shifted;
  logic signed [SAT_W-1:0] sat_v;

  logic accept, hit, last, col_last, row_last, col_in, row_in, idle;

  assign o_in_ready = reset && (!o_data_valid || i_out_ready);
  assign accept     = i_data_valid && o_in_ready;
  assign col_last   = (col == CW'(N - 1));
  assign row_last   = (row == RW'(M - 1));
  assign col_in     = (col >= CW'(K - 1));
  assign row_in     = (row >= RW'(K - 1));
  assign hit        = row_in && col_in && (cph == '0) && (rph == '0);
  assign last       = hit && (orow == RW'(OH - 1)) && (ocol == CW'(OW - 1));
  assign idle       = (row == '0) && (col == '0) && !o_data_valid;

  line_buffer #(.N(N), .ROWS(K - 1), .DW(DW)) u_line_buffer (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (accept),
    .col        (col),
    .din        (pxl_in),
    .col_data_c (lb_col_c)
  );

  // Raster position plus stride phase and output-map coordinate of the next window
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col  <= '0;
      row  <= '0;
      cph  <= '0;
      rph  <= '0;
      ocol <= '0;
      orow <= '0;
    end else if (accept) begin
      if (col_last) begin
        col  <= '0;
        cph  <= '0;
        ocol <= '0;
        if (row_last) begin
          row  <= '0;
          rph  <= '0;
          orow <= '0;
        end else begin
          row <= row + RW'(1);
          if (row_in) begin
            rph <= (rph == SW'(K_stride - 1)) ? '0 : rph + SW'(1);
            if (rph == '0) orow <= orow + RW'(1);
          end
        end
      end else begin
        col <= col + CW'(1);
        if (col_in) begin
          cph <= (cph == SW'(K_stride - 1)) ? '0 : cph + SW'(1);
          if (cph == '0) ocol <= ocol + CW'(1);
        end
      end
    end
  end

  // Window after this accept: shift left, new right column from line buffer + pxl_in
  always_comb begin
    for (int unsigned r = 0; r < K; r++)
      for (int unsigned q = 0; q + 1 < K; q++)
        nwin[r][q] = win[r][q+1];
    for (int unsigned r = 0; r + 1 < K; r++)
      nwin[r][K-1] = signed'(lb_col_c[r*DW +: DW]);
    nwin[K-1][K-1] = signed'(pxl_in);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned r = 0; r < K; r++)
        for (int unsigned q = 0; q < K; q++)
          win[r][q] <= '0;
    end else if (accept) begin
      for (int unsigned r = 0; r < K; r++)
        for (int unsigned q = 0; q < K; q++)
          win[r][q] <= nwin[r][q];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned c = 0; c < C_OUT; c++)
        for (int unsigned r = 0; r < K; r++)
          for (int unsigned q = 0; q < K; q++)
            wt[c][r][q] <= '0;
    end else if (i_kernel_load && idle) begin
      for (int unsigned c = 0; c < C_OUT; c++)
        for (int unsigned r = 0; r < K; r++)
          for (int unsigned q = 0; q < K; q++)
            wt[c][r][q] <= signed'(i_kernel_data[((c*K + r)*K + q)*DW +: DW]);
    end
  end

  // MAC trees on the incoming window, then rescale and clamp per channel
  always_comb begin
    res_c   = '0;
    acc     = '0;
    shifted = '0;
    sat_v   = '0;
    for (int unsigned c = 0; c < C_OUT; c++) begin
      acc = '0;
      for (int unsigned r = 0; r < K; r++)
        for (int unsigned q = 0; q < K; q++)
          acc = acc + ACC_W'(nwin[r][q]) * ACC_W'(wt[c][r][q]);
      shifted = SAT_W'(acc) >>> FRAC;
      sat_v   = sat_relu(shifted, DW, RELU != 0);
      res_c[c*DW +: DW] = DW'(sat_v);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pxl_out      <= '0;
      o_data_valid <= 1'b0;
      o_row        <= '0;
      o_col        <= '0;
      o_frame_done <= 1'b0;
    end else if (accept && hit) begin
      pxl_out      <= res_c;
      o_data_valid <= 1'b1;
      o_row        <= orow;
      o_col        <= ocol;
      o_frame_done <= last;
    end else if (o_data_valid && i_out_ready) begin
      o_data_valid <= 1'b0;
      o_frame_done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv_stream_mc.sv
// Directed bench for conv_stream_mc on a 6x6 image, K=3, two channels:
// instance 0 stride 1, instance 1 stride 2, instance 2 stride 1 with ReLU.
module tb_conv_stream_mc;

  localparam int N = 6, M = 6, K = 3, DW = 16, CO = 2;
  localparam int KW = CO * K * K * DW;
  localparam int LIMIT = 2000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [DW-1:0]    pxl_in [3];
  logic             dv     [3];
  logic             irdy   [3];
  logic [KW-1:0]    kdata  [3];
  logic             kload  [3];
  logic [CO*DW-1:0] pout   [3];
  logic             ov     [3];
  logic             ordy   [3];
  logic [2:0]       orow   [3];
  logic [2:0]       ocol   [3];
  logic             fdone  [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    conv_stream_mc #(
      .N(N), .M(M), .K(K), .K_stride(g == 1 ? 2 : 1), .DW(DW), .C_OUT(CO),
      .FRAC(0), .RELU(g == 2 ? 1 : 0)
    ) u_dut (
      .clk          (clk),
      .reset        (rst_n),
      .pxl_in       (pxl_in[g]),
      .i_data_valid (dv[g]),
      .o_in_ready   (irdy[g]),
      .i_kernel_data(kdata[g]),
      .i_kernel_load(kload[g]),
      .pxl_out      (pout[g]),
      .o_data_valid (ov[g]),
      .i_out_ready  (ordy[g]),
      .o_row        (orow[g]),
      .o_col        (ocol[g]),
      .o_frame_done (fdone[g])
    );
  end

  int img [36];
  int kw [2][9];
  logic [CO*DW-1:0] cap_d [$];
  int cap_r [$];
  int cap_c [$];
  bit cap_f [$];
  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // mode 0: zeros; 1: ch0 all-ones, ch1 centre only; 2: ch0 all-ones, ch1 all -1
  task automatic set_kw(input int mode);
    for (int i = 0; i < 9; i++) begin
      kw[0][i] = (mode == 0) ? 0 : 1;
      kw[1][i] = (mode == 0) ? 0 : (mode == 2) ? -1 : (i == 4) ? 1 : 0;
    end
  endtask

  task automatic set_img(input bool_ramp);
  endtask

  function automatic logic [KW-1:0] pack_k();
    logic [KW-1:0] p;
    p = '0;
    for (int c = 0; c < 2; c++)
      for (int i = 0; i < 9; i++)
        p[(c*9 + i)*DW +: DW] = 16'(kw[c][i]);
    return p;
  endfunction

  function automatic longint sat(input longint v, input bit relu);
    longint r;
    r = v;
    if (r > 32767) r = 32767;
    else if (r < -32768) r = -32768;
    if (relu && r < 0) r = 0;
    return r;
  endfunction

  task automatic load(input int idx);
    @(negedge clk);
    kdata[idx] = pack_k();
    kload[idx] = 1'b1;
    @(negedge clk);
    kload[idx] = 1'b0;
  endtask

  // Stream n_pix pixels of img, capturing every handshaken output word
  task automatic stream(input int idx, input int n_pix, input int stall_len,
                        input int load_at, input logic [KW-1:0] alt);
    int sent, cyc, stall_cnt;
    logic [CO*DW-1:0] held;
    bit stalling;
    sent = 0; cyc = 0; stall_cnt = 0; held = '0;
    cap_d.delete(); cap_r.delete(); cap_c.delete(); cap_f.delete();
    while (cyc < LIMIT) begin
      @(negedge clk);
      if (sent >= n_pix && !ov[idx]) break;
      stalling = ov[idx] && (stall_cnt < stall_len);
      if (stalling) begin
        if (stall_cnt == 0) held = pout[idx];
        stall_cnt++;
      end
      ordy[idx] = !stalling;
      dv[idx] = (sent < n_pix);
      if (sent < n_pix) pxl_in[idx] = 16'(img[sent]);
      kload[idx] = (sent == load_at);
      if (load_at >= 0) kdata[idx] = alt;
      #1;
      if (stalling) begin
        chk("stall_in_ready", 64'(irdy[idx]), 64'd0);
        chk("stall_hold", 64'(pout[idx]), 64'(held));
      end
      if (ov[idx] && ordy[idx]) begin
        cap_d.push_back(pout[idx]);
        cap_r.push_back(int'(orow[idx]));
        cap_c.push_back(int'(ocol[idx]));
        cap_f.push_back(fdone[idx]);
      end
      if (dv[idx] && irdy[idx]) sent++;
      cyc++;
    end
    dv[idx] = 1'b0;
    ordy[idx] = 1'b1;
    kload[idx] = 1'b0;
    if (cyc >= LIMIT) chk("stream_timeout", 64'd1, 64'd0);
  endtask

  // Reference convolution of img with kw over the captured words
  task automatic verify(input string tag, input int stride, input bit relu);
    int oh, ow, r, c;
    longint s;
    logic [CO*DW-1:0] e;
    oh = (M - K) / stride + 1;
    ow = (N - K) / stride + 1;
    chk({tag, "_count"}, 64'(cap_d.size()), 64'(oh * ow));
    for (int i = 0; i < oh * ow && i < cap_d.size(); i++) begin
      r = i / ow;
      c = i % ow;
      e = '0;
      for (int ch = 0; ch < 2; ch++) begin
        s = 0;
        for (int kr = 0; kr < 3; kr++)
          for (int kq = 0; kq < 3; kq++)
            s += longint'(img[(r*stride + kr)*N + c*stride + kq]) * kw[ch][kr*3 + kq];
        e[ch*DW +: DW] = 16'(sat(s, relu));
      end
      chk($sformatf("%s_w%0d_data", tag, i), 64'(cap_d[i]), 64'(e));
      chk($sformatf("%s_w%0d_row", tag, i), 64'(cap_r[i]), 64'(r));
      chk($sformatf("%s_w%0d_col", tag, i), 64'(cap_c[i]), 64'(c));
      chk($sformatf("%s_w%0d_done", tag, i), 64'(cap_f[i]), 64'(i == oh*ow - 1));
    end
  endtask

  initial begin
    int s2_c0 [4];
    int s2_c1 [4];
    logic [CO*DW-1:0] w;
    s2_c0 = '{72, 90, 180, 198};
    s2_c1 = '{8, 10, 20, 22};
    rst_n = 1'b0;
    for (int g = 0; g < 3; g++) begin
      pxl_in[g] = '0; dv[g] = 1'b0; kdata[g] = '0; kload[g] = 1'b0; ordy[g] = 1'b1;
    end
    for (int i = 0; i < 36; i++) img[i] = i + 1;

    // Reset state
    repeat (2) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      chk("rst_in_ready", 64'(irdy[g]), 64'd0);
      chk("rst_valid", 64'(ov[g]), 64'd0);
      chk("rst_pxl_out", 64'(pout[g]), 64'd0);
      chk("rst_row_col", 64'({orow[g], ocol[g]}), 64'd0);
      chk("rst_frame_done", 64'(fdone[g]), 64'd0);
    end
    rst_n = 1'b1;
    #1;
    for (int g = 0; g < 3; g++) chk("post_rst_in_ready", 64'(irdy[g]), 64'd1);

    // Continuous stream, stride 1, ones + centre kernels
    set_kw(1);
    load(0);
    stream(0, 36, 0, -1, '0);
    chk("s1_first", 64'(cap_d[0]), 64'({16'd8, 16'd72}));
    chk("s1_first_rc", 64'(cap_r[0] * 8 + cap_c[0]), 64'd0);
    chk("s1_last", 64'(cap_d[15]), 64'({16'd29, 16'd261}));
    chk("s1_last_rc", 64'(cap_r[15] * 8 + cap_c[15]), 64'(3 * 8 + 3));
    chk("s1_last_done", 64'(cap_f[15]), 64'd1);
    chk("s1_prev_done", 64'(cap_f[14]), 64'd0);
    verify("s1", 1, 1'b0);

    // Backpressure: hold the first word for 5 cycles
    stream(0, 36, 5, -1, '0);
    verify("hold", 1, 1'b0);

    // Stride 2
    load(1);
    stream(1, 36, 0, -1, '0);
    for (int i = 0; i < 4 && i < cap_d.size(); i++) begin
      w = cap_d[i];
      chk($sformatf("s2_w%0d", i), 64'(w), 64'({16'(s2_c1[i]), 16'(s2_c0[i])}));
      chk($sformatf("s2_w%0d_rc", i), 64'(cap_r[i] * 8 + cap_c[i]), 64'((i / 2) * 8 + i % 2));
    end
    verify("s2", 2, 1'b0);

    // Saturation, with and without ReLU
    for (int i = 0; i < 36; i++) img[i] = 32767;
    set_kw(2);
    load(0);
    stream(0, 36, 0, -1, '0);
    chk("sat_first", 64'(cap_d[0]), 64'(32'h8000_7FFF));
    verify("sat", 1, 1'b0);
    load(2);
    stream(2, 36, 0, -1, '0);
    chk("relu_first", 64'(cap_d[0]), 64'(32'h0000_7FFF));
    verify("relu", 1, 1'b1);

    // Mid-frame reset, then a frame on cleared weights with an ignored load
    for (int i = 0; i < 36; i++) img[i] = i + 1;
    set_kw(1);
    load(0);
    stream(0, 20, 0, -1, '0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", 64'(irdy[0]), 64'd0);
    chk("abort_valid", 64'(ov[0]), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    w = '0;
    stream(0, 36, 0, 10, pack_k());
    set_kw(0);
    chk("zero_first", 64'(cap_d[0]), 64'd0);
    verify("zero", 1, 1'b0);

    // Reload and repeat the first scenario
    set_kw(1);
    load(0);
    stream(0, 36, 0, -1, '0);
    chk("reload_first", 64'(cap_d[0]), 64'({16'd8, 16'd72}));
    chk("reload_last", 64'(cap_d[15]), 64'({16'd29, 16'd261}));
    verify("reload", 1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
